// File: rtl/snake_dir_arbiter_if.sv
// Direction-arbiter bus: debounced strobes and game controls in, committed heading and status out.
// The master side is the button/game logic, the slave side is the arbiter itself.
interface snake_dir_arbiter_if;
  logic       i_enable;
  logic       i_clear;
  logic       i_up;
  logic       i_right;
  logic       i_down;
  logic       i_left;
  logic       i_tick;
  logic [1:0] o_dir;
  logic       o_dir_changed;
  logic [1:0] o_q_count;
  logic       o_reject;
  logic       o_drop;

  modport master (
    output i_enable, i_clear, i_up, i_right, i_down, i_left, i_tick,
    input  o_dir, o_dir_changed, o_q_count, o_reject, o_drop
  );

  modport slave (
    input  i_enable, i_clear, i_up, i_right, i_down, i_left, i_tick,
    output o_dir, o_dir_changed, o_q_count, o_reject, o_drop
  );
endinterface

// File: rtl/snake_dir_arbiter.sv
// Turns single-cycle direction strobes into one legal snake heading per game tick,
// buffering up to QDEPTH pending turns in a small circular queue.
module snake_dir_arbiter #(
  parameter int unsigned QDEPTH   = 2,
  parameter logic [1:0]  INIT_DIR = 2'b01
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  snake_dir_arbiter_if.slave  bus
);

  localparam logic [1:0] LastIdx  = 2'(QDEPTH - 1);
  localparam logic [1:0] FullCnt  = 2'(QDEPTH);

  // Storage sized for the largest legal depth so 2-bit pointers index it cleanly.
  logic [1:0] r_q [4];
  logic [1:0] r_head;
  logic [1:0] r_tail;
  logic [1:0] r_count;
  logic [1:0] r_dir;
  logic       r_dir_changed;
  logic       r_reject;
  logic       r_drop;

  logic [1:0] w_q_nxt [4];
  logic [1:0] w_head_nxt;
  logic [1:0] w_tail_nxt;
  logic [1:0] w_count_nxt;
  logic [1:0] w_dir_nxt;
  logic       w_dir_changed_nxt;
  logic       w_reject_nxt;
  logic       w_drop_nxt;

  logic       w_cand_vld;
  logic [1:0] w_cand;
  logic [1:0] w_last_idx;
  logic [1:0] w_ref;
  logic [1:0] w_head_val;
  logic       w_illegal;
  logic       w_full;
  logic       w_pop;
  logic       w_push;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LastIdx) ? 2'd0 : p + 2'd1;
  endfunction

  // Candidate selection and legality against the most recent queued heading.
  always_comb begin
    w_cand_vld = bus.i_up | bus.i_right | bus.i_down | bus.i_left;
    if (bus.i_up)         w_cand = 2'b00;
    else if (bus.i_right) w_cand = 2'b01;
    else if (bus.i_down)  w_cand = 2'b10;
    else                  w_cand = 2'b11;

    w_last_idx = (r_tail == 2'd0) ? LastIdx : r_tail - 2'd1;
    w_ref      = (r_count != 2'd0) ? r_q[w_last_idx] : r_dir;
    w_head_val = r_q[r_head];
    w_illegal  = (w_cand == w_ref) || (w_cand == (w_ref ^ 2'b10));
    w_full     = (r_count == FullCnt);
    w_pop      = bus.i_tick && (r_count != 2'd0);
    // A pop in the same cycle frees the slot a full queue would otherwise lack.
    w_push     = w_cand_vld && !w_illegal && (!w_full || w_pop);
  end

  always_comb begin
    w_q_nxt           = r_q;
    w_head_nxt        = r_head;
    w_tail_nxt        = r_tail;
    w_count_nxt       = r_count;
    w_dir_nxt         = r_dir;
    w_dir_changed_nxt = 1'b0;
    w_reject_nxt      = 1'b0;
    w_drop_nxt        = 1'b0;

    if (bus.i_clear) begin
      w_dir_nxt   = INIT_DIR;
      w_head_nxt  = 2'd0;
      w_tail_nxt  = 2'd0;
      w_count_nxt = 2'd0;
    end else if (!bus.i_enable) begin
      w_head_nxt  = 2'd0;
      w_tail_nxt  = 2'd0;
      w_count_nxt = 2'd0;
    end else begin
      w_reject_nxt = w_cand_vld && w_illegal;
      w_drop_nxt   = w_cand_vld && !w_illegal && w_full && !w_pop;

      if (w_pop) begin
        w_dir_nxt         = w_head_val;
        w_dir_changed_nxt = (w_head_val != r_dir);
        w_head_nxt        = ptr_inc(r_head);
      end

      if (w_push) begin
        w_q_nxt[r_tail] = w_cand;
        w_tail_nxt      = ptr_inc(r_tail);
      end

      w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= 2'b00;
      end
      r_head        <= 2'd0;
      r_tail        <= 2'd0;
      r_count       <= 2'd0;
      r_dir         <= INIT_DIR;
      r_dir_changed <= 1'b0;
      r_reject      <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_q           <= w_q_nxt;
      r_head        <= w_head_nxt;
      r_tail        <= w_tail_nxt;
      r_count       <= w_count_nxt;
      r_dir         <= w_dir_nxt;
      r_dir_changed <= w_dir_changed_nxt;
      r_reject      <= w_reject_nxt;
      r_drop        <= w_drop_nxt;
    end
  end

  assign bus.o_dir         = r_dir;
  assign bus.o_dir_changed = r_dir_changed;
  assign bus.o_q_count     = r_count;
  assign bus.o_reject      = r_reject;
  assign bus.o_drop        = r_drop;

endmodule

// File: tb/tb_snake_dir_arbiter.sv
// Bench for snake_dir_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the turn rules.
module tb_snake_dir_arbiter;

  localparam int unsigned QD   = 2;
  localparam logic [1:0]  INIT = 2'b01;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  // Reference model state
  logic [1:0] mq[$];
  logic [1:0] mdir;
  logic       mchg;
  logic       mrej;
  logic       mdrop;

  snake_dir_arbiter_if u_if ();

  snake_dir_arbiter #(
    .QDEPTH   (QD),
    .INIT_DIR (INIT)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mdir  = INIT;
    mq.delete();
    mchg  = 1'b0;
    mrej  = 1'b0;
    mdrop = 1'b0;
  endtask

  task automatic model_step(input bit u, input bit r, input bit d, input bit l,
                            input bit t, input bit en, input bit clr);
    logic [1:0] c;
    logic [1:0] rf;
    logic [1:0] hd;
    bit has;
    bit pop;
    bit acc;
    mchg  = 1'b0;
    mrej  = 1'b0;
    mdrop = 1'b0;
    if (clr) begin
      mdir = INIT;
      mq.delete();
    end else if (!en) begin
      mq.delete();
    end else begin
      has = u | r | d | l;
      c   = u ? 2'd0 : r ? 2'd1 : d ? 2'd2 : 2'd3;
      rf  = (mq.size() > 0) ? mq[$] : mdir;
      pop = t && (mq.size() > 0);
      hd  = (mq.size() > 0) ? mq[0] : 2'd0;
      acc = 1'b0;
      if (has) begin
        if (c == rf || c == (rf ^ 2'b10)) mrej = 1'b1;
        else if (mq.size() == QD && !pop) mdrop = 1'b1;
        else acc = 1'b1;
      end
      if (pop) begin
        mchg = (hd != mdir);
        mdir = hd;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(c);
    end
  endtask

  // Applies one cycle of inputs, advances the model, returns #1 after the edge.
  task automatic drive(input bit u, input bit r, input bit d, input bit l,
                       input bit t, input bit en, input bit clr);
    u_if.i_up     = u;
    u_if.i_right  = r;
    u_if.i_down   = d;
    u_if.i_left   = l;
    u_if.i_tick   = t;
    u_if.i_enable = en;
    u_if.i_clear  = clr;
    model_step(u, r, d, l, t, en, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed, u_if.o_reject, u_if.o_drop}
        !== {INIT, 2'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset: got dir=%b cnt=%0d chg=%b rej=%b drop=%b, want dir=%b cnt=0 pulses=0",
               u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed, u_if.o_reject, u_if.o_drop, INIT);
    end
  endtask

  task automatic test_single_turn();
    drive(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (u_if.o_q_count !== 2'd1) begin
      n_err++;
      $display("FAIL single_count: got %0d want 1", u_if.o_q_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (u_if.o_dir !== 2'b01 || u_if.o_dir_changed !== 1'b0) begin
        n_err++;
        $display("FAIL single_wait: got dir=%b chg=%b want 01/0", u_if.o_dir, u_if.o_dir_changed);
      end
    end
    drive(0, 0, 0, 0, 1, 1, 0);
    n_cmp++;
    if ({u_if.o_dir, u_if.o_dir_changed, u_if.o_q_count} !== {2'b00, 1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL single_tick: got dir=%b chg=%b cnt=%0d want 00/1/0",
               u_if.o_dir, u_if.o_dir_changed, u_if.o_q_count);
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (u_if.o_dir_changed !== 1'b0) begin
      n_err++;
      $display("FAIL single_pulse_width: got chg=%b want 0", u_if.o_dir_changed);
    end
  endtask

  task automatic test_reversal();
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0, 1, 0);
    n_cmp++;
    if ({u_if.o_reject, u_if.o_drop, u_if.o_q_count} !== {1'b1, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL reversal: got rej=%b drop=%b cnt=%0d want 1/0/0",
               u_if.o_reject, u_if.o_drop, u_if.o_q_count);
    end
    drive(0, 1, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({u_if.o_reject, u_if.o_q_count} !== {1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL repeat: got rej=%b cnt=%0d want 1/0", u_if.o_reject, u_if.o_q_count);
    end
    drive(1, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({u_if.o_reject, u_if.o_q_count} !== {1'b0, 2'd1}) begin
      n_err++;
      $display("FAIL accept_up: got rej=%b cnt=%0d want 0/1", u_if.o_reject, u_if.o_q_count);
    end
    drive(0, 0, 1, 0, 0, 1, 0);
    n_cmp++;
    if ({u_if.o_reject, u_if.o_q_count, u_if.o_dir} !== {1'b1, 2'd1, 2'b01}) begin
      n_err++;
      $display("FAIL tail_reversal: got rej=%b cnt=%0d dir=%b want 1/1/01",
               u_if.o_reject, u_if.o_q_count, u_if.o_dir);
    end
  endtask

  task automatic test_queue_full();
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    n_cmp++;
    if (u_if.o_q_count !== 2'd2) begin
      n_err++;
      $display("FAIL full_count: got %0d want 2", u_if.o_q_count);
    end
    drive(0, 0, 1, 0, 0, 1, 0);
    n_cmp++;
    if ({u_if.o_drop, u_if.o_reject, u_if.o_q_count} !== {1'b1, 1'b0, 2'd2}) begin
      n_err++;
      $display("FAIL full_drop: got drop=%b rej=%b cnt=%0d want 1/0/2",
               u_if.o_drop, u_if.o_reject, u_if.o_q_count);
    end
    drive(0, 0, 0, 0, 1, 1, 0);
    n_cmp++;
    if ({u_if.o_dir, u_if.o_q_count, u_if.o_drop} !== {2'b00, 2'd1, 1'b0}) begin
      n_err++;
      $display("FAIL full_tick1: got dir=%b cnt=%0d drop=%b want 00/1/0",
               u_if.o_dir, u_if.o_q_count, u_if.o_drop);
    end
    drive(0, 0, 0, 0, 1, 1, 0);
    n_cmp++;
    if ({u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed} !== {2'b11, 2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL full_tick2: got dir=%b cnt=%0d chg=%b want 11/0/1",
               u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed);
    end
  endtask

  task automatic test_simultaneous();
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 1, 0, 1, 0);
    n_cmp++;
    if ({u_if.o_q_count, u_if.o_reject, u_if.o_drop} !== {2'd1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL simul_press: got cnt=%0d rej=%b drop=%b want 1/0/0",
               u_if.o_q_count, u_if.o_reject, u_if.o_drop);
    end
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 1, 1, 0);
    n_cmp++;
    if ({u_if.o_q_count, u_if.o_dir, u_if.o_drop, u_if.o_dir_changed}
        !== {2'd2, 2'b00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL full_tick_push: got cnt=%0d dir=%b drop=%b chg=%b want 2/00/0/1",
               u_if.o_q_count, u_if.o_dir, u_if.o_drop, u_if.o_dir_changed);
    end
  endtask

  task automatic test_clear_enable();
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    n_cmp++;
    if ({u_if.o_dir, u_if.o_q_count} !== {2'b01, 2'd0}) begin
      n_err++;
      $display("FAIL clear: got dir=%b cnt=%0d want 01/0", u_if.o_dir, u_if.o_q_count);
    end
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    n_cmp++;
    if ({u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed, u_if.o_reject, u_if.o_drop}
        !== {2'b00, 2'd0, 3'b000}) begin
      n_err++;
      $display("FAIL disable1: got dir=%b cnt=%0d chg=%b rej=%b drop=%b want 00/0/0/0/0",
               u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed, u_if.o_reject, u_if.o_drop);
    end
    drive(0, 1, 0, 0, 1, 0, 0);
    n_cmp++;
    if ({u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed, u_if.o_reject, u_if.o_drop}
        !== {2'b00, 2'd0, 3'b000}) begin
      n_err++;
      $display("FAIL disable2: got dir=%b cnt=%0d chg=%b rej=%b drop=%b want 00/0/0/0/0",
               u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed, u_if.o_reject, u_if.o_drop);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 1, 0);
    n_cmp++;
    if ({u_if.o_dir, u_if.o_q_count, u_if.o_reject} !== {2'b10, 2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset: got dir=%b cnt=%0d rej=%b want 10/2/1",
               u_if.o_dir, u_if.o_q_count, u_if.o_reject);
    end
    u_if.i_down = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed, u_if.o_reject, u_if.o_drop}
        !== {INIT, 2'd0, 3'b000}) begin
      n_err++;
      $display("FAIL async_reset: got dir=%b cnt=%0d chg=%b rej=%b drop=%b want 01/0/0/0/0",
               u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed, u_if.o_reject, u_if.o_drop);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({u_if.o_dir, u_if.o_q_count} !== {2'b01, 2'd1}) begin
      n_err++;
      $display("FAIL post_reset: got dir=%b cnt=%0d want 01/1", u_if.o_dir, u_if.o_q_count);
    end
  endtask

  task automatic test_random();
    logic [6:0] got;
    logic [6:0] exp;
    bit u, r, d, l, t, en, clr;
    for (int i = 0; i < 800; i++) begin
      u   = ($urandom_range(0, 99) < 20);
      r   = ($urandom_range(0, 99) < 20);
      d   = ($urandom_range(0, 99) < 20);
      l   = ($urandom_range(0, 99) < 20);
      t   = ($urandom_range(0, 99) < 15);
      en  = ($urandom_range(0, 99) < 95);
      clr = ($urandom_range(0, 99) < 2);
      drive(u, r, d, l, t, en, clr);
      exp = {mdir, 2'(mq.size()), mchg, mrej, mdrop};
      got = {u_if.o_dir, u_if.o_q_count, u_if.o_dir_changed, u_if.o_reject, u_if.o_drop};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random[%0d] {dir,cnt,chg,rej,drop}: got %b want %b", i, got, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.i_enable = 1'b0;
    u_if.i_clear  = 1'b0;
    u_if.i_up     = 1'b0;
    u_if.i_right  = 1'b0;
    u_if.i_down   = 1'b0;
    u_if.i_left   = 1'b0;
    u_if.i_tick   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 0);
    test_reset();
    test_single_turn();
    test_reversal();
    test_queue_full();
    test_simultaneous();
    test_clear_enable();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
